// File: rtl/lift_call_scheduler.sv
// Latches floor calls and paces the lift controller one floor per step pulse, dwelling at served floors.
// Optional move watchdog: define LIFT_SCHED_WATCHDOG_EN.
module lift_call_scheduler #(
  parameter int unsigned NUM_FLOORS   = 5,
  parameter int unsigned FLOOR_W      = 3,
  parameter int unsigned DWELL_CYCLES = 3,
  parameter int unsigned MOVE_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  up_signal,
  output logic                  down_signal,
  output logic                  door_open,
  output logic                  moving_dir,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic                  fault
);

  localparam int unsigned DwellW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 1 || MOVE_TIMEOUT < 1) begin : gen_param_check
    $error("lift_call_scheduler: DWELL_CYCLES and MOVE_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStepUp,
    StStepDn,
    StSettle,
    StDwell
`ifdef LIFT_SCHED_WATCHDOG_EN
    , StFault
`endif
  } state_e;

  state_e                state_q, state_d, decision;
  logic [NUM_FLOORS-1:0] pending_q, floor_hot, clear_mask;
  logic [DwellW-1:0]     dwell_q;
  logic                  up_q, dn_q, door_q, dir_q, busy_q;
  logic                  hit, above, below;
  int unsigned           cf;

`ifdef LIFT_SCHED_WATCHDOG_EN
  localparam int unsigned TmoW = $clog2(MOVE_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MOVE_TIMEOUT - 1);

  logic [FLOOR_W-1:0] start_floor_q;
  logic [TmoW-1:0]    tmo_q;
  logic               fault_q;

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // An out-of-range floor sits above every floor: nothing is above, everything is below.
  always_comb begin
    cf        = 32'(current_floor);
    floor_hot = '0;
    above     = 1'b0;
    below     = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      floor_hot[i] = (i == cf);
      above        = above | (pending_q[i] && (i > cf));
      below        = below | (pending_q[i] && (i < cf));
    end
    hit = |(pending_q & floor_hot);

    if (hit)                 decision = StDwell;
    else if (!dir_q && above) decision = StStepUp;
    else if (dir_q && below)  decision = StStepDn;
    else if (above)           decision = StStepUp;
    else if (below)           decision = StStepDn;
    else                      decision = StIdle;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:             state_d = decision;
      StStepUp, StStepDn: state_d = StSettle;
      StSettle: begin
`ifdef LIFT_SCHED_WATCHDOG_EN
        if (current_floor != start_floor_q) state_d = decision;
        else if (tmo_q == TmoLast)          state_d = StFault;
`else
        state_d = decision;
`endif
      end
      StDwell:            if (dwell_q == '0) state_d = decision;
`ifdef LIFT_SCHED_WATCHDOG_EN
      StFault:            state_d = StFault;
`endif
      default:            state_d = StIdle;
    endcase
  end

  // Serving clears the current floor on entry and keeps absorbing it for the whole dwell.
  assign clear_mask = (state_q == StDwell || state_d == StDwell) ? floor_hot : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      dwell_q   <= '0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      door_q    <= 1'b0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef LIFT_SCHED_WATCHDOG_EN
      start_floor_q <= '0;
      tmo_q         <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= (pending_q | call_req) & ~clear_mask;
      up_q      <= (state_d == StStepUp);
      dn_q      <= (state_d == StStepDn);
      door_q    <= (state_d == StDwell);
      busy_q    <= (state_d != StIdle);
      if (state_d == StStepUp)      dir_q <= 1'b0;
      else if (state_d == StStepDn) dir_q <= 1'b1;
      if (state_d == StDwell && (state_q != StDwell || dwell_q == '0)) begin
        dwell_q <= DwellLast;
      end else if (state_q == StDwell && dwell_q != '0) begin
        dwell_q <= dwell_q - DwellW'(1);
      end
`ifdef LIFT_SCHED_WATCHDOG_EN
      fault_q <= (state_d == StFault);
      if (state_d == StStepUp || state_d == StStepDn) begin
        start_floor_q <= current_floor;
        tmo_q         <= '0;
      end else if (state_q == StSettle && state_d == StSettle) begin
        tmo_q <= tmo_q + TmoW'(1);
      end
`endif
    end
  end

  assign up_signal   = up_q;
  assign down_signal = dn_q;
  assign door_open   = door_q;
  assign moving_dir  = dir_q;
  assign pending     = pending_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler with a simple floor-stepping controller model and an
// event scoreboard (step pulses and door openings, tagged with the floor they occur at).
module tb_lift_call_scheduler;

  localparam int unsigned NF    = 5;
  localparam int unsigned FW    = 3;
  localparam int unsigned DWELL = 3;
  localparam int unsigned TMO   = 4;

  localparam int EvUp   = 16;
  localparam int EvDn   = 32;
  localparam int EvDoor = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NF-1:0] call_req = '0;
  logic [FW-1:0] floor = '0;
  logic          up_signal, down_signal, door_open, moving_dir, busy, fault;
  logic [NF-1:0] pending;

  logic          set_en = 1'b0;
  logic [FW-1:0] set_val = '0;
  logic          frozen = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_q[$];
  logic door_prev = 1'b0;
  int   door_len = 0;

  always #5 clk = ~clk;

  lift_call_scheduler #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (FW),
    .DWELL_CYCLES(DWELL),
    .MOVE_TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .call_req     (call_req),
    .current_floor(floor),
    .up_signal    (up_signal),
    .down_signal  (down_signal),
    .door_open    (door_open),
    .moving_dir   (moving_dir),
    .pending      (pending),
    .busy         (busy),
    .fault        (fault)
  );

  // Controller model: moves one floor on each step pulse.
  always @(posedge clk) begin
    if (set_en) floor <= set_val;
    else if (!frozen) begin
      if (up_signal)        floor <= floor + 3'd1;
      else if (down_signal) floor <= floor - 3'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int ev);
    exp_q.push_back(ev);
  endtask

  task automatic monitor();
    int ev = 0;
    check("up_dn_exclusive", 32'(up_signal & down_signal), 0);
    if (up_signal)                    ev = EvUp + int'(floor);
    else if (down_signal)             ev = EvDn + int'(floor);
    else if (door_open && !door_prev) ev = EvDoor + int'(floor);
    if (ev != 0) begin
      if (exp_q.size() == 0) check("unexpected_event", ev, 0);
      else                   check("event", ev, exp_q.pop_front());
    end
    if (door_open) door_len++;
    else if (door_prev) begin
      check("door_len", door_len, DWELL);
      door_len = 0;
    end
    door_prev = door_open;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [NF-1:0] mask);
    call_req = mask;
    tick();
    call_req = '0;
  endtask

  task automatic set_floor(input logic [FW-1:0] v);
    set_en  = 1'b1;
    set_val = v;
    tick();
    set_en  = 1'b0;
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    repeat (3) tick();
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    // Reset held with every call button pressed.
    #2 rst = 1'b0;
    call_req = '1;
    repeat (3) tick();
    check("rst_up", 32'(up_signal), 0);
    check("rst_down", 32'(down_signal), 0);
    check("rst_door", 32'(door_open), 0);
    check("rst_dir", 32'(moving_dir), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_pending", 32'(pending), 0);
    call_req = '0;
    rst = 1'b1;
    repeat (4) tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_pending", 32'(pending), 0);

    // Ground floor, call 3: three up steps then a dwell at 3.
    expect_ev(EvUp + 0);
    expect_ev(EvUp + 1);
    expect_ev(EvUp + 2);
    expect_ev(EvDoor + 3);
    press(5'b01000);
    run_until_idle("s1");
    check("s1_floor", 32'(floor), 3);
    check("s1_pending", 32'(pending), 0);
    check("s1_dir", 32'(moving_dir), 0);

    // Call 4 from ground; an intermediate call for 2 is served on the way.
    set_floor(3'd0);
    expect_ev(EvUp + 0);
    expect_ev(EvUp + 1);
    expect_ev(EvDoor + 2);
    expect_ev(EvUp + 2);
    expect_ev(EvUp + 3);
    expect_ev(EvDoor + 4);
    press(5'b10000);
    n = 0;
    while (floor != 3'd1 && n < 20) begin
      tick();
      n++;
    end
    check("s2_reach_floor1", 32'(floor), 1);
    press(5'b00100);
    run_until_idle("s2");
    check("s2_floor", 32'(floor), 4);

    // At 3 heading up with calls 4 and 1: finish upward first, then reverse.
    set_floor(3'd3);
    check("s3_dir_before", 32'(moving_dir), 0);
    expect_ev(EvUp + 3);
    expect_ev(EvDoor + 4);
    expect_ev(EvDn + 4);
    expect_ev(EvDn + 3);
    expect_ev(EvDn + 2);
    expect_ev(EvDoor + 1);
    press(5'b10010);
    check("s3_pending_latched", 32'(pending), 32'(5'b10010));
    run_until_idle("s3");
    check("s3_dir_after", 32'(moving_dir), 1);
    check("s3_floor", 32'(floor), 1);

    // Call for the current floor: immediate dwell; repeats during dwell are absorbed.
    set_floor(3'd2);
    expect_ev(EvDoor + 2);
    press(5'b00100);
    n = 0;
    while (door_open !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("s4_door_opened", 32'(door_open), 1);
    call_req = 5'b00100;
    for (int i = 0; i < int'(DWELL); i++) begin
      tick();
      check("s4_absorbed", 32'(pending[2]), 0);
    end
    call_req = '0;
    run_until_idle("s4");
    check("s4_pending", 32'(pending), 0);

    // Out-of-range floor reads as above every floor.
    set_floor(3'd7);
    expect_ev(EvDn + 7);
    expect_ev(EvDn + 6);
    expect_ev(EvDn + 5);
    expect_ev(EvDoor + 4);
    press(5'b10000);
    run_until_idle("s5");
    check("s5_floor", 32'(floor), 4);

    // Reset in the middle of a move drops the outstanding call.
    expect_ev(EvDn + 4);
    press(5'b00001);
    n = 0;
    while (down_signal !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    tick();
    rst = 1'b0;
    #1;
    check("s6_rst_busy", 32'(busy), 0);
    check("s6_rst_pending", 32'(pending), 0);
    check("s6_rst_dir", 32'(moving_dir), 0);
    rst = 1'b1;
    repeat (6) tick();
    check("s6_quiet_busy", 32'(busy), 0);
    check("s6_q_empty", exp_q.size(), 0);

`ifdef LIFT_SCHED_WATCHDOG_EN
    // Frozen controller: one pulse, then fault after the move timeout.
    frozen = 1'b1;
    set_floor(3'd0);
    expect_ev(EvUp + 0);
    press(5'b00100);
    n = 0;
    while (fault !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("wd_fault", 32'(fault), 1);
    check("wd_latency", n, 2 + TMO);
    repeat (6) tick();
    check("wd_fault_hold", 32'(fault), 1);
    check("wd_pending", 32'(pending), 32'(5'b00100));
    check("wd_q_empty", exp_q.size(), 0);
    rst = 1'b0;
    #1;
    check("wd_rst_fault", 32'(fault), 0);
    rst = 1'b1;
    frozen = 1'b0;
`else
    check("fault_tied_low", 32'(fault), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
